// File: rtl/mul_mdc_ctrl_pkg.sv
// Shared types and constants for the multi_dataflow_mul_mdc job sequencer.
package mul_mdc_ctrl_pkg;

    localparam int NUM_IN = 3;
    localparam int DW_DEF = 32;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

endpackage

// File: rtl/mul_mdc_job_ctrl_if.sv
// Stream bundle between sources, the mul_mdc network and the result sink.
interface mul_mdc_job_ctrl_if #(parameter int DW = 32);
    import mul_mdc_ctrl_pkg::*;

    logic [NUM_IN-1:0][DW-1:0] src_data;
    logic [NUM_IN-1:0]         src_valid;
    logic [NUM_IN-1:0]         src_ready;
    logic [NUM_IN-1:0][DW-1:0] in_stream_data;
    logic [NUM_IN-1:0]         in_stream_wr;
    logic [NUM_IN-1:0]         in_stream_full;
    logic [DW-1:0]             out_stream_data;
    logic                      out_stream_wr;
    logic                      out_stream_full;
    logic [DW-1:0]             snk_data;
    logic                      snk_valid;
    logic                      snk_ready;

    modport master (
        input  src_data, src_valid, in_stream_full, out_stream_data, out_stream_wr, snk_ready,
        output src_ready, in_stream_data, in_stream_wr, out_stream_full, snk_data, snk_valid
    );

    modport slave (
        output src_data, src_valid, in_stream_full, out_stream_data, out_stream_wr, snk_ready,
        input  src_ready, in_stream_data, in_stream_wr, out_stream_full, snk_data, snk_valid
    );

endinterface

// File: rtl/mul_mdc_skid.sv
// Two-entry skid buffer on the network result path; full is derived from registered occupancy.
module mul_mdc_skid #(
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          full,
    output logic          valid,
    output logic [DW-1:0] data,
    input  logic          ready,
    output logic          pop
);

    logic [DW-1:0] mem [2];
    logic          wptr, rptr;
    logic [1:0]    cnt;
    logic          do_push;

    assign full    = cnt[1];
    assign valid   = |cnt;
    assign data    = mem[rptr];
    assign pop     = valid & ready;
    assign do_push = push & ~full;

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wptr   <= 1'b0;
            rptr   <= 1'b0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            cnt <= cnt + 2'(do_push) - 2'(pop);
        end
    end

endmodule

// File: rtl/mul_mdc_job_ctrl.sv
// Job sequencer for multi_dataflow_mul_mdc: latches config, meters three input
// streams, counts results through a skid buffer and aborts stalled jobs.
module mul_mdc_job_ctrl import mul_mdc_ctrl_pkg::*; #(
    parameter int DW             = DW_DEF,
    parameter int LW             = LW_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] cfg_len,
    input  logic [LW-1:0] cfg_out_len,
    input  logic [31:0]   cfg_simple_mul,
    input  logic [7:0]    cfg_shift,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [31:0]   reg_simple_mul,
    output logic [7:0]    reg_shift,
    output logic [LW-1:0] reg_len,
    mul_mdc_job_ctrl_if.master bus
);

    localparam bit            WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [LW-1:0] WD_LAST = LW'(TIMEOUT_CYCLES - 1);

    state_t                    state, state_nxt;
    logic [LW-1:0]             len_q, out_len_q, out_cnt, wd_cnt;
    logic [NUM_IN-1:0][LW-1:0] in_cnt;
    logic                      timeout_q;
    logic                      capture, pop, progress, all_in, wd_fire;

    assign capture = bus.out_stream_wr & ~bus.out_stream_full;
    assign progress = (|bus.in_stream_wr) | capture | pop;
    assign wd_fire = WD_EN && busy && !progress && (wd_cnt == WD_LAST);
    assign bus.in_stream_data = bus.src_data;
    assign timeout = timeout_q;
    assign reg_len = len_q;

    always_comb begin
        all_in = 1'b1;
        for (int n = 0; n < NUM_IN; n++)
            if (in_cnt[n] != len_q) all_in = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (all_in) state_nxt = DRAIN;
            DRAIN:   if (out_cnt == out_len_q && !bus.snk_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A stalled job is dropped without done; the skid keeps whatever it holds.
        if (wd_fire) state_nxt = IDLE;
    end

    always_comb begin
        busy          = (state == RUN) || (state == DRAIN);
        done          = (state == DONE);
        bus.src_ready = '0;
        for (int n = 0; n < NUM_IN; n++)
            bus.src_ready[n] = (state == RUN) & bus.src_valid[n] & ~bus.in_stream_full[n]
                             & (in_cnt[n] != len_q);
        bus.in_stream_wr = bus.src_ready;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            len_q          <= '0;
            out_len_q      <= '0;
            reg_simple_mul <= '0;
            reg_shift      <= '0;
            in_cnt         <= '0;
            out_cnt        <= '0;
            wd_cnt         <= '0;
            timeout_q      <= 1'b0;
        end else if (state == IDLE && start) begin
            len_q          <= cfg_len;
            out_len_q      <= cfg_out_len;
            reg_simple_mul <= cfg_simple_mul;
            reg_shift      <= cfg_shift;
            in_cnt         <= '0;
            out_cnt        <= '0;
            wd_cnt         <= '0;
            timeout_q      <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_IN; n++)
                if (bus.in_stream_wr[n]) in_cnt[n] <= in_cnt[n] + 1'b1;
            // Surplus results still reach the sink but the count saturates.
            if (busy && capture && out_cnt != out_len_q) out_cnt <= out_cnt + 1'b1;
            if (wd_fire) timeout_q <= 1'b1;
            if (!WD_EN || !busy || progress) wd_cnt <= '0;
            else                              wd_cnt <= wd_cnt + 1'b1;
        end
    end

    mul_mdc_skid #(.DW(DW)) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (bus.out_stream_wr),
        .push_data (bus.out_stream_data),
        .full      (bus.out_stream_full),
        .valid     (bus.snk_valid),
        .data      (bus.snk_data),
        .ready     (bus.snk_ready),
        .pop       (pop)
    );

endmodule

// File: tb/tb_mul_mdc_job_ctrl.sv
// Bench for mul_mdc_job_ctrl: random jobs through an a*b+c network model plus directed corner cases.
module tb_mul_mdc_job_ctrl;
    import mul_mdc_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_len = '0, cfg_out_len = '0;
    logic [31:0]   cfg_simple_mul = '0;
    logic [7:0]    cfg_shift = '0;
    logic          busy, done, timeout;
    logic [31:0]   reg_simple_mul;
    logic [7:0]    reg_shift;
    logic [LW-1:0] reg_len;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] srcw [NUM_IN][64];
    logic [DW-1:0] q0[$], q1[$], q2[$];
    logic [DW-1:0] expq[$];

    mul_mdc_job_ctrl_if #(.DW(DW)) bus();

    mul_mdc_job_ctrl #(.DW(DW), .LW(LW), .TIMEOUT_CYCLES(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .cfg_len        (cfg_len),
        .cfg_out_len    (cfg_out_len),
        .cfg_simple_mul (cfg_simple_mul),
        .cfg_shift      (cfg_shift),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .reg_simple_mul (reg_simple_mul),
        .reg_shift      (reg_shift),
        .reg_len        (reg_len),
        .bus            (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_bus();
        bus.src_data        = '0;
        bus.src_valid       = '0;
        bus.in_stream_full  = '0;
        bus.out_stream_data = '0;
        bus.out_stream_wr   = 1'b0;
        bus.snk_ready       = 1'b0;
    endtask

    // One job: sources offer random words, the network computes a*b+c per triple,
    // and every sink word is compared against values computed from the source arrays.
    task automatic run_job(input int len, input int vprob, input int rprob, input int stall_at);
        int          sidx[NUM_IN];
        int          wr[NUM_IN];
        int          cyc;
        bit          fin, len_bad, stall_bad, stall;
        logic [31:0] mul_v;
        logic [DW-1:0] e;
        for (int n = 0; n < NUM_IN; n++) begin
            sidx[n] = 0;
            wr[n] = 0;
            for (int k = 0; k < 64; k++) srcw[n][k] = $urandom;
        end
        expq.delete(); q0.delete(); q1.delete(); q2.delete();
        for (int k = 0; k < len; k++) expq.push_back(srcw[0][k] * srcw[1][k] + srcw[2][k]);
        mul_v = $urandom;
        cfg_len = LW'(len); cfg_out_len = LW'(len); cfg_simple_mul = mul_v; cfg_shift = 8'(len + 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_len = LW'(len + 5); cfg_simple_mul = ~mul_v;
        chk("start_busy", busy, 1);
        chk("reg_simple_mul", reg_simple_mul, mul_v);
        chk("reg_shift", reg_shift, 8'(len + 3));
        fin = 0; len_bad = 0; stall_bad = 0; cyc = 0;
        while (!fin && cyc < 3000) begin
            start = (cyc == 2);
            for (int n = 0; n < NUM_IN; n++) begin
                bus.src_valid[n] = ($urandom_range(99) < vprob);
                if (sidx[n] < len) bus.src_data[n] = srcw[n][sidx[n]];
                else               bus.src_data[n] = 32'hdead_0000 + DW'(n);
            end
            stall = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 10);
            bus.in_stream_full = {1'b0, stall, 1'b0};
            bus.out_stream_wr = (q0.size() > 0) && (q1.size() > 0) && (q2.size() > 0)
                                && ($urandom_range(99) < 80);
            if (bus.out_stream_wr) bus.out_stream_data = q0[0] * q1[0] + q2[0];
            bus.snk_ready = ($urandom_range(99) < rprob);
            #4;
            if (stall && bus.src_ready[1]) stall_bad = 1;
            if (reg_len !== LW'(len)) len_bad = 1;
            for (int n = 0; n < NUM_IN; n++) begin
                if (bus.in_stream_wr[n]) begin
                    if (n == 0) q0.push_back(bus.in_stream_data[0]);
                    else if (n == 1) q1.push_back(bus.in_stream_data[1]);
                    else q2.push_back(bus.in_stream_data[2]);
                    sidx[n]++;
                    wr[n]++;
                end
            end
            if (bus.out_stream_wr && !bus.out_stream_full) begin
                void'(q0.pop_front()); void'(q1.pop_front()); void'(q2.pop_front());
            end
            if (bus.snk_valid && bus.snk_ready) begin
                if (expq.size() == 0) chk("snk_extra_word", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("snk_data", bus.snk_data, e);
                end
            end
            tick();
            cyc++;
            if (done) begin
                fin = 1;
                chk("busy_low_at_done", busy, 0);
            end
        end
        start = 1'b0;
        chk("done_seen", fin, 1);
        for (int n = 0; n < NUM_IN; n++) chk("in_writes", wr[n], len);
        chk("snk_words_missing", expq.size(), 0);
        chk("reg_len_stable", len_bad, 0);
        chk("stalled_stream_accepted", stall_bad, 0);
        chk("job_timeout", timeout, 0);
        idle_bus();
        // start during the DONE cycle must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_single_pulse", done, 0);
        chk("start_in_done_ignored", busy, 0);
        chk("reg_len_held", reg_len, len);
    endtask

    initial begin
        idle_bus();
        bus.src_valid = '1;
        reset = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_in_wr", bus.in_stream_wr, 0);
        chk("rst_snk_valid", bus.snk_valid, 0);
        chk("rst_out_full", bus.out_stream_full, 0);
        chk("rst_reg_len", reg_len, 0);
        chk("rst_reg_mul", reg_simple_mul, 0);
        reset = 1'b1;
        idle_bus();
        tick();

        run_job(4, 100, 100, -1);
        run_job(8, 100, 100, 3);
        run_job(12, 60, 50, -1);
        run_job(20, 70, 60, 5);

        // Sink stall with three network writes while idle.
        bus.snk_ready = 1'b0;
        bus.out_stream_wr = 1'b1;
        bus.out_stream_data = 32'h1111_0001;
        tick();
        chk("skid_lat_valid", bus.snk_valid, 1);
        chk("skid_lat_data", bus.snk_data, 32'h1111_0001);
        chk("skid_full_1", bus.out_stream_full, 0);
        bus.out_stream_data = 32'h2222_0002;
        tick();
        chk("skid_full_2", bus.out_stream_full, 1);
        chk("skid_head_2", bus.snk_data, 32'h1111_0001);
        bus.out_stream_data = 32'h3333_0003;
        tick();
        chk("skid_full_hold", bus.out_stream_full, 1);
        chk("skid_head_hold", bus.snk_data, 32'h1111_0001);
        bus.snk_ready = 1'b1;
        tick();
        chk("skid_pop1_full", bus.out_stream_full, 0);
        chk("skid_pop1_data", bus.snk_data, 32'h2222_0002);
        tick();
        chk("skid_pushpop_valid", bus.snk_valid, 1);
        chk("skid_pushpop_data", bus.snk_data, 32'h3333_0003);
        bus.out_stream_wr = 1'b0;
        tick();
        chk("skid_empty", bus.snk_valid, 0);
        idle_bus();

        // Watchdog: stream 2 never offers data.
        cfg_len = 16'd3; cfg_out_len = 16'd3;
        bus.src_valid = 3'b011;
        bus.snk_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        chk("wd_busy_before", busy, 1);
        chk("wd_timeout_before", timeout, 0);
        tick();
        chk("wd_timeout", timeout, 1);
        chk("wd_busy_after", busy, 0);
        chk("wd_no_done", done, 0);
        tick();
        chk("wd_sticky", timeout, 1);
        chk("wd_no_done_later", done, 0);

        // Zero-length job; its start also clears the timeout flag.
        bus.src_valid = '0;
        cfg_len = '0; cfg_out_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_timeout_cleared", timeout, 0);
        chk("zero_busy_run", busy, 1);
        chk("zero_no_wr", bus.in_stream_wr, 0);
        tick();
        chk("zero_busy_drain", busy, 1);
        chk("zero_done_early", done, 0);
        tick();
        chk("zero_done", done, 1);
        chk("zero_busy_done", busy, 0);
        tick();
        chk("zero_done_once", done, 0);

        // Reset while in DRAIN.
        cfg_len = 16'd1; cfg_out_len = 16'd1;
        bus.src_valid = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("drain_busy", busy, 1);
        chk("drain_inputs_closed", bus.src_ready, 0);
        reset = 1'b0;
        start = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_timeout", timeout, 0);
        chk("mid_rst_reg_len", reg_len, 0);
        chk("mid_rst_snk_valid", bus.snk_valid, 0);
        chk("mid_rst_full", bus.out_stream_full, 0);
        reset = 1'b1;
        start = 1'b0;
        tick();
        chk("start_in_reset_ignored", busy, 0);
        chk("post_rst_done", done, 0);
        idle_bus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
